// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: filters, coalesces and queues resolved-branch updates, and runs flush walks.
// Optional BTBQ_STATS_EN adds saturating filtered/dropped update counters.
module btb_update_ctrl #(
  parameter int QDEPTH = 4,
  parameter int NWAY   = 8,
  parameter int AW     = 32,
  localparam int QW    = $clog2(QDEPTH),
  localparam int WW    = (NWAY > 1) ? $clog2(NWAY) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          upd0_valid,
  input  logic [AW-1:0] upd0_pc,
  input  logic [AW-1:0] upd0_target,
  input  logic          upd1_valid,
  input  logic [AW-1:0] upd1_pc,
  input  logic [AW-1:0] upd1_target,
  output logic          upd_ready,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          btb_wr_valid,
  output logic          btb_wr_inv,
  output logic [WW-1:0] btb_wr_way,
  output logic [AW-1:0] btb_wr_pc,
  output logic [AW-1:0] btb_wr_target,
  input  logic          btb_wr_ready,
  output logic [QW:0]   q_count
`ifdef BTBQ_STATS_EN
  ,
  output logic [15:0]   stat_filtered,
  output logic [15:0]   stat_dropped
`endif
);

  typedef enum logic [1:0] {IDLE, FWAIT, FLUSH} state_t;

  state_t state, state_nxt;
  logic flush_pend;

  logic [AW-1:0] pc_mem  [QDEPTH];
  logic [AW-1:0] tgt_mem [QDEPTH];
  logic [QW-1:0] wptr, rptr, tail_ptr;
  logic [QW:0]   count;

  logic idle, hs, can_load, pop_old, bypass, pop, clear;
  logic tail_ok, last_way;
  logic fall0, fall1, ok0, ok1, coll, p0;
  logic coal0, coal1, push0, push1;
  logic [AW-1:0] head_pc, head_tgt;

  assign q_count  = count;
  assign idle     = (state == IDLE);
  assign hs       = btb_wr_valid & btb_wr_ready;
  assign last_way = (btb_wr_way == WW'(NWAY - 1));
  assign tail_ptr = wptr - 1'b1;

  assign fall0 = (upd0_target == upd0_pc + AW'(4));
  assign fall1 = (upd1_target == upd1_pc + AW'(4));
  assign ok0   = upd0_valid & upd_ready & ~fall0;
  assign ok1   = upd1_valid & upd_ready & ~fall1;
  assign coll  = ok0 & ok1 & (upd0_pc == upd1_pc);
  assign p0    = ok0 & ~coll;

  // Coalescing only sees entries that stay queued after this cycle's pop.
  assign can_load = (~btb_wr_valid | hs) & ~stall & idle;
  assign pop_old  = can_load & (count != '0);
  assign tail_ok  = (count > (QW+1)'(pop_old));

  assign coal0 = p0 & tail_ok & (upd0_pc == pc_mem[tail_ptr]);
  assign push0 = p0 & ~coal0;
  assign coal1 = ok1 & ~p0 & tail_ok & (upd1_pc == pc_mem[tail_ptr]);
  assign push1 = ok1 & ~coal1;

  assign bypass = can_load & (count == '0) & (push0 | push1);
  assign pop    = pop_old | bypass;
  assign clear  = (state == FWAIT) & (~btb_wr_valid | hs);

  always_comb begin
    head_pc  = pc_mem[rptr];
    head_tgt = tgt_mem[rptr];
    if (count == '0) begin
      head_pc  = push0 ? upd0_pc : upd1_pc;
      head_tgt = push0 ? upd0_target : upd1_target;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      pc_mem[wptr]  <= upd0_pc;
      tgt_mem[wptr] <= upd0_target;
    end
    if (push1) begin
      pc_mem[wptr + QW'(push0)]  <= upd1_pc;
      tgt_mem[wptr + QW'(push0)] <= upd1_target;
    end
    if (coal0) tgt_mem[tail_ptr] <= upd0_target;
    if (coal1) tgt_mem[tail_ptr] <= upd1_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + QW'(push0) + QW'(push1);
      rptr  <= rptr + QW'(pop);
      count <= count + (QW+1)'(push0) + (QW+1)'(push1) - (QW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (flush_pend) state_nxt = FWAIT;
      FWAIT:   if (clear) state_nxt = FLUSH;
      FLUSH:   if (hs && last_way) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flush_busy = flush_pend | ~idle;
    upd_ready  = ~rst & idle & ~flush_pend
               & (count <= (QW+1)'(QDEPTH - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (state == FLUSH && hs && last_way) begin
      flush_pend <= 1'b0;
    end else if (flush_req && idle && !flush_pend) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_wr_valid  <= 1'b0;
      btb_wr_inv    <= 1'b0;
      btb_wr_way    <= '0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (can_load && (count != '0 || push0 || push1)) begin
            btb_wr_valid  <= 1'b1;
            btb_wr_inv    <= 1'b0;
            btb_wr_way    <= '0;
            btb_wr_pc     <= head_pc;
            btb_wr_target <= head_tgt;
          end else if (hs) begin
            btb_wr_valid <= 1'b0;
          end
        end
        FWAIT: begin
          if (clear) begin
            btb_wr_valid  <= 1'b1;
            btb_wr_inv    <= 1'b1;
            btb_wr_way    <= '0;
            btb_wr_pc     <= '0;
            btb_wr_target <= '0;
          end
        end
        FLUSH: begin
          if (hs) begin
            if (last_way) begin
              btb_wr_valid <= 1'b0;
              btb_wr_inv   <= 1'b0;
              btb_wr_way   <= '0;
            end else begin
              btb_wr_way <= btb_wr_way + 1'b1;
            end
          end
        end
        default: btb_wr_valid <= 1'b0;
      endcase
    end
  end

`ifdef BTBQ_STATS_EN
  logic [16:0] filt_sum, drop_sum;

  always_comb begin
    filt_sum = {1'b0, stat_filtered}
             + 17'(upd0_valid & upd_ready & fall0)
             + 17'(upd1_valid & upd_ready & fall1)
             + 17'(coll) + 17'(coal0) + 17'(coal1);
    drop_sum = {1'b0, stat_dropped}
             + 17'(upd0_valid & ~upd_ready)
             + 17'(upd1_valid & ~upd_ready)
             + (clear ? 17'(count) : 17'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_filtered <= '0;
      stat_dropped  <= '0;
    end else begin
      stat_filtered <= filt_sum[16] ? 16'hFFFF : filt_sum[15:0];
      stat_dropped  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on the accepted-write log.
module tb_btb_update_ctrl;
  localparam int Q  = 4;
  localparam int N  = 8;
  localparam int AW = 32;

  logic clk = 0, rst = 1, stall = 0, flush_req = 0, wr_ready = 0;
  logic v0 = 0, v1 = 0;
  logic [AW-1:0] p0 = 0, t0 = 0, p1 = 0, t1 = 0;

  logic          upd_ready, flush_busy;
  logic          btb_wr_valid, btb_wr_inv;
  logic [2:0]    btb_wr_way;
  logic [AW-1:0] btb_wr_pc, btb_wr_target;
  logic [2:0]    q_count;
`ifdef BTBQ_STATS_EN
  logic [15:0]   stat_filtered, stat_dropped;
`endif

  btb_update_ctrl #(.QDEPTH(Q), .NWAY(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .upd0_valid(v0), .upd0_pc(p0), .upd0_target(t0),
    .upd1_valid(v1), .upd1_pc(p1), .upd1_target(t1),
    .upd_ready(upd_ready), .flush_req(flush_req), .flush_busy(flush_busy),
    .btb_wr_valid(btb_wr_valid), .btb_wr_inv(btb_wr_inv),
    .btb_wr_way(btb_wr_way), .btb_wr_pc(btb_wr_pc),
    .btb_wr_target(btb_wr_target), .btb_wr_ready(wr_ready),
    .q_count(q_count)
`ifdef BTBQ_STATS_EN
    ,
    .stat_filtered(stat_filtered), .stat_dropped(stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic        inv;
    int          way;
    logic [31:0] pc;
    logic [31:0] tgt;
  } wr_t;

  int errors = 0;
  int checks = 0;

  ent_t mq[$];
  wr_t  wlog[$];
  logic m_v = 0, m_inv = 0, pend = 0;
  int   m_way = 0, mode = 0;
  logic [31:0] m_pc = 0, m_tgt = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input ent_t e);
    m_v = 1; m_inv = 0; m_way = 0; m_pc = e.pc; m_tgt = e.tgt;
  endtask

  // Reference behaviour: survivors are merged into a queue, the queue head
  // (or the first fresh update when empty) feeds a single write slot.
  task automatic model_step();
    logic rdy, hs, cl, took;
    ent_t s[$];
    ent_t e;
    rdy = (mode == 0) && !pend && (mq.size() <= Q - 2);
    hs  = m_v && wr_ready;
    if (mode == 0) begin
      cl = (!m_v || hs) && !stall;
      took = 0;
      if (hs) m_v = 0;
      if (cl && mq.size() > 0) begin
        e = mq.pop_front(); load(e); took = 1;
      end
      if (rdy && v0 && t0 != p0 + 32'd4) s.push_back({p0, t0});
      if (rdy && v1 && t1 != p1 + 32'd4) s.push_back({p1, t1});
      if (s.size() == 2 && s[0].pc == s[1].pc) void'(s.pop_front());
      foreach (s[i]) begin
        if (mq.size() > 0 && mq[mq.size()-1].pc == s[i].pc) begin
          e = mq[mq.size()-1]; e.tgt = s[i].tgt; mq[mq.size()-1] = e;
        end else begin
          mq.push_back(s[i]);
        end
      end
      if (cl && !took && mq.size() > 0) begin
        e = mq.pop_front(); load(e);
      end
      if (pend) mode = 1;
      else if (flush_req) pend = 1;
    end else if (mode == 1) begin
      if (!m_v || hs) begin
        mode = 2; mq.delete();
        m_v = 1; m_inv = 1; m_way = 0;
      end
    end else begin
      if (hs) begin
        if (m_way == N - 1) begin
          mode = 0; pend = 0; m_v = 0; m_inv = 0; m_way = 0;
        end else begin
          m_way++;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_v = 0; m_inv = 0; m_way = 0; mode = 0; pend = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    check("upd_ready", 32'(upd_ready),
          32'(!rst && mode == 0 && !pend && mq.size() <= Q - 2));
    check("flush_busy", 32'(flush_busy), 32'(pend || mode != 0));
    check("q_count", 32'(q_count), 32'(mq.size()));
    check("wr_valid", 32'(btb_wr_valid), 32'(m_v));
    if (m_v) begin
      check("wr_inv", 32'(btb_wr_inv), 32'(m_inv));
      if (m_inv) check("wr_way", 32'(btb_wr_way), 32'(m_way));
      else begin
        check("wr_pc", btb_wr_pc, m_pc);
        check("wr_tgt", btb_wr_target, m_tgt);
      end
    end
    if (!rst && btb_wr_valid && wr_ready)
      wlog.push_back('{btb_wr_inv, int'(btb_wr_way), btb_wr_pc, btb_wr_target});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_upd();
    v0 = 0; v1 = 0;
  endtask

  initial begin
    bit found;
    tick(2);
    check("rst_valid", 32'(btb_wr_valid), 0);
    check("rst_ready", 32'(upd_ready), 0);
    check("rst_qcnt", 32'(q_count), 0);
    rst = 0;
    #1;
    check("rel_ready", 32'(upd_ready), 1);

    // single update, immediate write
    wr_ready = 1;
    v0 = 1; p0 = 32'h1000; t0 = 32'h2000;
    tick(1); clr_upd();
    check("t1_valid", 32'(btb_wr_valid), 1);
    check("t1_pc", btb_wr_pc, 32'h1000);
    check("t1_tgt", btb_wr_target, 32'h2000);
    check("t1_inv", 32'(btb_wr_inv), 0);
    check("t1_qcnt", 32'(q_count), 0);
    tick(2);
    check("t1_nwr", wlog.size(), 1);

    // fall-through filter on pipe0
    wlog.delete();
    v0 = 1; p0 = 32'h1000; t0 = 32'h1004;
    v1 = 1; p1 = 32'h2000; t1 = 32'h3000;
    tick(1); clr_upd(); tick(3);
    check("t2_nwr", wlog.size(), 1);
    if (wlog.size() > 0) begin
      check("t2_pc", wlog[0].pc, 32'h2000);
      check("t2_tgt", wlog[0].tgt, 32'h3000);
    end

    // same-pc collision keeps the younger target
    wlog.delete();
    v0 = 1; p0 = 32'h4000; t0 = 32'h5000;
    v1 = 1; p1 = 32'h4000; t1 = 32'h6000;
    tick(1); clr_upd(); tick(3);
    check("t3_nwr", wlog.size(), 1);
    if (wlog.size() > 0) check("t3_tgt", wlog[0].tgt, 32'h6000);

    // stall holds the entry in the FIFO
    wlog.delete();
    stall = 1;
    v0 = 1; p0 = 32'h600; t0 = 32'h680;
    tick(1); clr_upd();
    check("st_valid", 32'(btb_wr_valid), 0);
    check("st_qcnt", 32'(q_count), 1);
    stall = 0;
    tick(1);
    check("st_valid2", 32'(btb_wr_valid), 1);
    check("st_pc", btb_wr_pc, 32'h600);
    tick(2);

    // backpressure: FIFO fills, upd_ready drops at 3 entries
    wlog.delete();
    wr_ready = 0;
    for (int i = 0; i < 6; i++) begin
      v0 = 1; p0 = 32'h100 + 32'(16 * i); t0 = 32'h9000 + 32'(16 * i);
      tick(1);
      if (i == 3) begin
        check("t4_qcnt3", 32'(q_count), 3);
        check("t4_ready0", 32'(upd_ready), 0);
      end
    end
    clr_upd();
    check("t4_hold_pc", btb_wr_pc, 32'h100);
    wr_ready = 1;
    tick(6);
    check("t4_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      check("t4_pc", wlog[i].pc, 32'h100 + 32'(16 * i));
      check("t4_tgt", wlog[i].tgt, 32'h9000 + 32'(16 * i));
    end

    // flush behind a stalled in-flight write
    wlog.delete();
    wr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      v0 = 1; p0 = 32'h500 + 32'(16 * i); t0 = 32'h700 + 32'(16 * i);
      tick(1);
    end
    clr_upd();
    flush_req = 1;
    tick(1);
    flush_req = 0;
    check("t5_busy", 32'(flush_busy), 1);
    tick(2);
    check("t5_qcnt", 32'(q_count), 2);
    wr_ready = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (!flush_busy) found = 1;
    end
    check("t5_done", 32'(found), 1);
    check("t5_nwr", wlog.size(), 9);
    if (wlog.size() == 9) begin
      check("t5_first_pc", wlog[0].pc, 32'h500);
      check("t5_first_inv", 32'(wlog[0].inv), 0);
      for (int k = 0; k < N; k++) begin
        check("t5_inv", 32'(wlog[k+1].inv), 1);
        check("t5_way", wlog[k+1].way, k);
      end
    end
    check("t5_qcnt0", 32'(q_count), 0);
    tick(2);

    // reset in the middle of a walk
    flush_req = 1;
    tick(1);
    flush_req = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (btb_wr_valid && btb_wr_inv && btb_wr_way == 3'd3) found = 1;
    end
    check("t6_way3", 32'(found), 1);
    rst = 1;
    #1;
    check("t6_valid", 32'(btb_wr_valid), 0);
    check("t6_inv", 32'(btb_wr_inv), 0);
    check("t6_way", 32'(btb_wr_way), 0);
    check("t6_busy", 32'(flush_busy), 0);
    tick(1);
    rst = 0;
    wlog.delete();
    tick(1);
    v0 = 1; p0 = 32'h800; t0 = 32'h900;
    tick(1); clr_upd(); tick(3);
    check("t6_nwr", wlog.size(), 1);
    if (wlog.size() > 0) begin
      check("t6_pc", wlog[0].pc, 32'h800);
      check("t6_inv2", 32'(wlog[0].inv), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Scheduler in front of the branch target buffer's single write port.
- Accepts resolved-branch updates from two issue pipes. Filters useless updates, buffers them in a small FIFO and issues them one per handshake.
- Sequences a full-BTB invalidate (flush walk) on request.
- Sits between the execute-stage branch resolution logic and the BTB write interface.

Parameters:
QDEPTH, 4, FIFO entries; power of 2, at least 2
NWAY, 8, BTB ways walked during flush; way index width is clog2(NWAY)
AW, 32, PC/target width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stall  in  1  high: output register is not reloaded; a held write stays held
upd0_valid  in  1  pipe0 (older) update present
upd0_pc  in  AW  delay-slot PC of pipe0 branch
upd0_target  in  AW  resolved target of pipe0 branch
upd1_valid  in  1  pipe1 (younger) update present
upd1_pc  in  AW  delay-slot PC of pipe1 branch
upd1_target  in  AW  resolved target of pipe1 branch
upd_ready  out  1  both update ports may push this cycle
flush_req  in  1  single-cycle pulse requesting a BTB invalidate walk
flush_busy  out  1  flush pending or walk in progress
btb_wr_valid  out  1  write request to BTB
btb_wr_inv  out  1  1 = invalidate btb_wr_way; 0 = install pc/target
btb_wr_way  out  clog2(NWAY)  way index, meaningful only when btb_wr_inv=1
btb_wr_pc  out  AW  PC to install
btb_wr_target  out  AW  target to install
btb_wr_ready  in  1  BTB accepts the write this cycle
q_count  out  clog2(QDEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, FSM=IDLE, flush pending cleared. Exception: upd_ready=0 while rst=1 and 1 after release.
- upd_ready = (FSM==IDLE) & ~flush_pend & (QDEPTH - q_count >= 2).
- Updates presented while upd_ready=0 are discarded. Updates are hints; the producer never retries.
- Filter on each port: drop if target == pc+4 (AW-bit wrap add), i.e. a fall-through branch.
- Same-cycle collision: if both ports survive the filter and pc0==pc1, push only upd1 (the younger).
- Push order: upd0 is pushed before upd1. Up to 2 pushes per cycle.
- Tail coalesce: if a surviving update's pc equals the current tail entry's pc, overwrite the tail target instead of pushing. This check also applies to upd1 against the upd0 just pushed.
- Output register:
  - loaded from the FIFO head when it is empty, or when the handshake completes this cycle, and stall=0 and FSM=IDLE.
  - A FIFO entry pushed at cycle T appears on btb_wr_valid at T+1 at the earliest.
- Handshake: once btb_wr_valid=1, btb_wr_valid/inv/way/pc/target are held stable until the cycle btb_wr_ready=1, independent of stall.
- Simultaneous push and pop are allowed. q_count updates by pushes minus pops.
- FSM states:
  - IDLE: drains FIFO to the BTB.
  - FWAIT: flush pending; waits for any in-flight write to complete.
  - FLUSH: walks ways.
- flush_req in IDLE sets flush_pend; flush_busy=1 the next cycle.
- IDLE -> FWAIT on flush_pend.
- FWAIT -> FLUSH once no write is outstanding (btb_wr_valid=0, or handshake this cycle).
- On entry to FLUSH: FIFO cleared and q_count=0; pending updates are discarded.
- FLUSH issues btb_wr_inv=1 with btb_wr_way = 0,1,...,NWAY-1, one way per accepted handshake. The way advances only on btb_wr_ready. stall is ignored in FLUSH.
- FLUSH -> IDLE the cycle after way NWAY-1 is accepted. flush_busy and flush_pend clear at that point.
- flush_req while flush_busy=1 is ignored (no re-arm).
- Reset asserted mid-walk or mid-handshake aborts immediately to reset state.

Optional Feature:
- Macro BTBQ_STATS_EN.
- When defined: adds outputs stat_filtered[15:0] and stat_dropped[15:0], both saturating at 16'hFFFF and cleared by rst.
  - stat_filtered increments once per update removed by the fall-through filter, the collision rule or coalescing.
  - stat_dropped increments once per valid update discarded due to upd_ready=0 or a FIFO clear. Simultaneous events on both ports add 2.
- When undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Single update pc=0x1000 target=0x2000 into an empty FIFO, btb_wr_ready=1 -> btb_wr_valid=1 next cycle with pc=0x1000 target=0x2000 inv=0; q_count returns to 0.
- upd0 pc=0x1000 target=0x1004 plus upd1 pc=0x2000 target=0x3000 -> first is filtered; only 0x2000/0x3000 is written; stat_filtered=1 if enabled.
- Both ports pc=0x4000, targets 0x5000/0x6000 -> one write with target 0x6000.
- btb_wr_ready=0 for 6 cycles with updates arriving each cycle, QDEPTH=4 -> upd_ready drops at q_count=3; outputs stay stable; writes drain in FIFO order after ready rises.
- flush_req with 2 entries queued and an in-flight write stalled 3 cycles -> in-flight write completes; FIFO is cleared; 8 inv writes with way 0..7; flush_busy falls after way 7 is accepted.
- rst pulse mid-flush at way 3 -> all outputs 0 immediately; a post-reset update is written normally with no inv writes.
